// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// Module : pc_fetch_unit_pkg
// Brief  : Shared encodings and constants for the PC / instruction-fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

  localparam int          FETCH_XLEN   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// ============================================================================
// Module : pc_next_sel
// Brief  : Combinational next-PC selection: redirect target, sequential step
//          or hold. Optional macro: PC_MISALIGN_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            en,
  input  logic            advance,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            zero,
  input  logic [XLEN-1:0] PCout,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign
`endif
);

  logic            take;
  logic [XLEN-1:0] target;

  assign take   = en && ex_valid && (Jump || (Branch && zero));
  assign target = PCout & ~XLEN'(2'b11);

`ifdef PC_MISALIGN_CHECK_EN
  // A misaligned target suppresses the redirect; the fetch unit halts instead.
  assign misalign = take && (PCout[1:0] != 2'b00);
  assign redirect = take && !misalign;
`else
  assign redirect = take;
`endif

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = target;
    end else if (advance && !stall) begin
      next_pc = pc + XLEN'(PC_STEP);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module : pc_fetch_unit
// Brief  : PC register, instruction-memory req/ready handshake and redirect
//          handling. Optional macro: PC_MISALIGN_CHECK_EN (halt on misaligned
//          redirect target, sticky misalign_err).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            zero,
  input  logic [XLEN-1:0] PCout,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] PCin,
  output logic            flush,
  output logic            misalign_err
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            drop;
  logic            redirect;
  logic            abort;
  logic            handshake;
  logic            accept;

`ifdef PC_MISALIGN_CHECK_EN
  logic            misalign;
`endif

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .pc       (pc),
    .en       ((state == REQ) || (state == OUT)),
    .advance  (state == OUT),
    .stall    (stall),
    .ex_valid (ex_valid),
    .Branch   (Branch),
    .Jump     (Jump),
    .zero     (zero),
    .PCout    (PCout),
    .next_pc  (next_pc),
    .redirect (redirect)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign (misalign)
`endif
  );

`ifdef PC_MISALIGN_CHECK_EN
  assign abort = redirect || misalign;
`else
  assign abort = redirect;
`endif

  assign handshake = imem_req && imem_ready;
  // Data is kept only if no redirect has invalidated it (earlier or now).
  assign accept    = handshake && !drop && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (accept) begin
          state_n = OUT;
        end
      end
      OUT: begin
        if (redirect || !stall) begin
          state_n = REQ;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      HALT: state_n = HALT;
`endif
      default: state_n = IDLE;
    endcase
`ifdef PC_MISALIGN_CHECK_EN
    if (misalign) begin
      state_n = HALT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      inst       <= INST_NOP;
      inst_valid <= 1'b0;
      PCin       <= RESET_PC;
      flush      <= 1'b0;
      drop       <= 1'b0;
    end else begin
      pc    <= next_pc;
      flush <= abort;
      // The outstanding address stays put until its handshake completes.
      if (!((state == REQ) && !handshake)) begin
        imem_addr <= next_pc;
      end
      if (state == REQ) begin
        if (handshake) begin
          drop <= 1'b0;
        end else if (redirect) begin
          drop <= 1'b1;
        end
      end
      if (accept) begin
        inst <= imem_rdata;
        PCin <= pc;
      end
      if (abort) begin
        inst_valid <= 1'b0;
      end else if (accept) begin
        inst_valid <= 1'b1;
      end else if ((state == OUT) && !stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (misalign) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module : tb_pc_fetch_unit
// Brief  : Scoreboard bench for pc_fetch_unit (optionally PC_MISALIGN_CHECK_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, Branch, Jump, zero, stall;
  logic [31:0] PCout;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata, inst, PCin;
  logic        inst_valid, flush, misalign_err;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] sb[$];
  logic        vld_q    = 1'b0;

  always #5 clk = ~clk;

  // Memory model: instruction word derived from the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[27:0], 4'h0};
  endfunction

  assign imem_rdata = mem(imem_addr);

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .Branch       (Branch),
    .Jump         (Jump),
    .zero         (zero),
    .PCout        (PCout),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .PCin         (PCin),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a request to addr now; the response is queued and returned next edge.
  task automatic expect_fetch(input logic [31:0] addr);
    check_eq("req_high", 32'(imem_req), 32'd1);
    check_eq("req_addr", imem_addr, addr);
    sb.push_back(addr);
    imem_ready = 1'b1;
    tick();
  endtask

  // Each newly presented instruction is popped against the scoreboard.
  always @(negedge clk) begin
    if (inst_valid && !vld_q) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_inst", 32'(inst_valid), 32'd0);
      end else begin
        logic [31:0] a;
        a = sb.pop_front();
        check_eq("sb_pcin", PCin, a);
        check_eq("sb_inst", inst, mem(a));
      end
    end
    vld_q <= inst_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
    PCout = 32'h0; stall = 1'b0; imem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req",      32'(imem_req),     32'd0);
    check_eq("rst_addr",     imem_addr,         32'h0);
    check_eq("rst_inst",     inst,              32'h0000_0013);
    check_eq("rst_valid",    32'(inst_valid),   32'd0);
    check_eq("rst_pcin",     PCin,              32'h0);
    check_eq("rst_flush",    32'(flush),        32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);

    // Reset release: one IDLE cycle, then the first request to RESET_PC.
    rst = 1'b0;
    tick();
    expect_fetch(32'h0);
    check_eq("first_inst", inst, 32'h0050_0093);
    check_eq("first_pcin", PCin, 32'h0);

    // Stall holds the instruction and suppresses requests.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_req",   32'(imem_req),   32'd0);
      check_eq("stall_valid", 32'(inst_valid), 32'd1);
      check_eq("stall_pcin",  PCin,            32'h0);
      check_eq("stall_inst",  inst,            32'h0050_0093);
    end
    stall = 1'b0;
    tick();
    expect_fetch(32'h4);

    // Taken branch while a request to 8 is outstanding.
    imem_ready = 1'b0;
    tick();
    check_eq("wait_addr8", imem_addr, 32'h8);
    ex_valid = 1'b1; Branch = 1'b1; zero = 1'b1; PCout = 32'h40;
    tick();
    ex_valid = 1'b0; Branch = 1'b0; zero = 1'b0;
    check_eq("br_flush",     32'(flush), 32'd1);
    check_eq("br_addr_held", imem_addr,  32'h8);
    tick();
    check_eq("br_flush_off", 32'(flush), 32'd0);
    check_eq("br_addr_held2", imem_addr, 32'h8);
    imem_ready = 1'b1;
    tick();
    check_eq("br_discard_valid", 32'(inst_valid), 32'd0);
    expect_fetch(32'h40);

    // Branch not taken: sequential fetch continues.
    ex_valid = 1'b1; Branch = 1'b1; zero = 1'b0; PCout = 32'h80;
    tick();
    ex_valid = 1'b0; Branch = 1'b0;
    check_eq("nt_flush", 32'(flush), 32'd0);
    expect_fetch(32'h44);

    // Jump to a target with low bits set.
    ex_valid = 1'b1; Jump = 1'b1; PCout = 32'h103;
    tick();
    ex_valid = 1'b0; Jump = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    check_eq("mis_err",   32'(misalign_err), 32'd1);
    check_eq("mis_flush", 32'(flush),        32'd1);
    check_eq("mis_valid", 32'(inst_valid),   32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halt_req", 32'(imem_req),     32'd0);
      check_eq("halt_err", 32'(misalign_err), 32'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("halt_rst_err", 32'(misalign_err), 32'd0);
    tick();
    expect_fetch(32'h0);
`else
    check_eq("jmp_flush", 32'(flush),        32'd1);
    check_eq("jmp_valid", 32'(inst_valid),   32'd0);
    check_eq("jmp_err",   32'(misalign_err), 32'd0);
    expect_fetch(32'h100);
`endif

    // Wrap-around from the top of the address space.
    ex_valid = 1'b1; Jump = 1'b1; PCout = 32'hFFFF_FFFC;
    tick();
    ex_valid = 1'b0; Jump = 1'b0;
    check_eq("wrap_flush", 32'(flush), 32'd1);
    expect_fetch(32'hFFFF_FFFC);
    tick();
    expect_fetch(32'h0);

    // Back-to-back redirects: latest target wins, flush on each.
    imem_ready = 1'b0;
    tick();
    check_eq("b2b_addr4", imem_addr, 32'h4);
    ex_valid = 1'b1; Jump = 1'b1; PCout = 32'h200;
    tick();
    check_eq("b2b_flush1", 32'(flush), 32'd1);
    PCout = 32'h300;
    tick();
    ex_valid = 1'b0; Jump = 1'b0;
    check_eq("b2b_flush2", 32'(flush), 32'd1);
    check_eq("b2b_addr_held", imem_addr, 32'h4);
    tick();
    check_eq("b2b_flush_off", 32'(flush), 32'd0);
    imem_ready = 1'b1;
    tick();
    check_eq("b2b_discard_valid", 32'(inst_valid), 32'd0);
    expect_fetch(32'h300);

    // Reset while a request is outstanding; a late ready must be ignored.
    imem_ready = 1'b0;
    tick();
    check_eq("rr_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rr_req_off", 32'(imem_req),   32'd0);
    check_eq("rr_valid",   32'(inst_valid), 32'd0);
    check_eq("rr_addr",    imem_addr,       32'h0);
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check_eq("rr_late_valid", 32'(inst_valid), 32'd0);
    tick();
    tick();
    check_eq("rr_still_invalid", 32'(inst_valid), 32'd0);
    expect_fetch(32'h0);
    tick();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
